pwm_preconditioner: RTL and testbench
=====================================

// Module: pwm_preconditioner
// PURPOSE
//  Converts per-transducer duty/phase/cycle settings into absolute PWM rise/fall edge counts.
//  Sits between the duty/phase source (modulator/STM output) and the PWM generator.
//  The PWM generator compares these edges against the per-transducer time counts.
//  Walks all DEPTH transducers one per clock into a shadow bank.
//  Commits the whole bank in one cycle, so the PWM stage never sees a mixed set.
// PARAMETERS
//  WIDTH  13   bit width of cycle, duty, phase, rise and fall values
//  DEPTH  249  number of transducers
// PORTS
//  CLK    in   1             system clock (163.84 MHz domain)
//  RST    in   1             asynchronous, active-high reset
//  START  in   1             1-cycle pulse: sample inputs and begin a pass
//  CYCLE  in   [WIDTH-1:0]x DEPTH  per-transducer PWM period in counts
//  DUTY   in   [WIDTH-1:0]x DEPTH  per-transducer pulse width
//  PHASE  in   [WIDTH-1:0]x DEPTH  per-transducer pulse centre (phase < cycle)
//  RISE   out  [WIDTH-1:0]x DEPTH  committed rise edge
//  FALL   out  [WIDTH-1:0]x DEPTH  committed fall edge
//  FULL   out  DEPTH         committed flag: duty_eff == cycle (output held high)
//  BUSY   out  1             pass in progress
//  DONE   out  1             1-cycle pulse in the cycle after commit
// BEHAVIOUR
//  Reset: RISE/FALL/FULL all 0, BUSY=0, DONE=0, state IDLE, index 0, shadow bank cleared.
//  FSM states:
//   - IDLE -> RUN on START; CYCLE/DUTY/PHASE are registered on that edge. START in RUN/COMMIT is ignored.
//   - RUN: index i goes 0..DEPTH-1, one per clock. Stage 1 selects element i. Stage 2 computes and writes shadow[i].
//   - RUN -> COMMIT after the last write.
//   - COMMIT: shadow is copied to RISE/FALL/FULL in a single cycle -> IDLE; DONE pulses the following cycle.
//  Timing:
//   - START-to-commit latency is DEPTH+2 clocks.
//   - BUSY is high from the cycle after START through COMMIT.
//   - Outputs are stable at all other times.
//  Arithmetic (unsigned, WIDTH+1-bit intermediates, no overflow):
//   - d_lo = duty_eff>>1; d_hi = duty_eff - d_lo.
//   - rise = phase>=d_lo ? phase-d_lo : phase+cycle-d_lo.
//   - f = phase+d_hi; fall = f>=cycle ? f-cycle : f.
//   - FULL = (duty_eff == cycle).
//  Boundary cases:
//   - duty 0: rise == fall == phase, FULL=0 (output low).
//   - duty == cycle: rise == fall, FULL=1.
//   - Odd duty: the extra count goes to the fall side.
//   - Index wraps only via COMMIT; DEPTH=1 is legal (latency 3).
//   - Reset mid-pass: abandons the pass, clears outputs, no DONE.
//   - START coincident with COMMIT: ignored.
//   - phase >= cycle is a caller error; results undefined, no hang.
// CONFIGURATION
//  `PWM_DUTY_CLAMP_EN defined: duty_eff = min(DUTY, CYCLE); duty > cycle behaves as duty == cycle (FULL=1).
//  Not defined: duty_eff = DUTY with no compare logic. The caller guarantees DUTY <= CYCLE; otherwise results are undefined.
// STRUCTURE
//  Package pwm_pkg holds:
//   - typedef enum {IDLE, RUN, COMMIT} pwm_pre_state_t
//   - default WIDTH/DEPTH localparams
//   - typedef logic [WIDTH-1:0] pwm_cnt_t
//  Sub-module pwm_edge_calc: registered single-stage computation of rise, fall and full from one (cycle, duty, phase) triple.
//  Instantiated once and time-multiplexed over the index.
// TESTING
//  1. cycle=4096, duty=2048, phase=0 -> rise=3072, fall=1024, FULL=0; DONE exactly DEPTH+3 clocks after START.
//  2. cycle=4096, duty=0, phase=100 -> rise=fall=100, FULL=0. Then duty=3, phase=0 -> rise=4095, fall=2.
//  3. Element DEPTH-1: cycle=4097, duty=4097, phase=4096 -> rise=fall=2048, FULL=1; elements 0..DEPTH-2 unaffected.
//  4. With `PWM_DUTY_CLAMP_EN: cycle=4096, duty=5000, phase=0 -> rise=fall=2048, FULL=1.
//  5. Atomicity: run pass A to completion, then change inputs and START pass B.
//     -> RISE/FALL stay equal to A every cycle until B's commit cycle, then all become B at once.
//     -> A second START while BUSY causes no restart and no extra DONE.
//  6. Assert RST at index 100 mid-pass -> outputs 0, BUSY=0, no DONE.
//     After release, a fresh START completes normally with correct values.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM preconditioner.
// Default geometry: 13-bit counts, 249 transducers.
package pwm_pkg;

    localparam int PWM_WIDTH = 13;
    localparam int PWM_DEPTH = 249;

    typedef logic [PWM_WIDTH-1:0] pwm_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT
    } pwm_pre_state_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// Registered rise/fall/full computation for one (cycle, duty, phase) triple.
// Define PWM_DUTY_CLAMP_EN to clamp duty to cycle before the edge math.
module pwm_edge_calc #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cycle,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] phase,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             full
);

    logic [WIDTH:0] c;
    logic [WIDTH:0] p;
    logic [WIDTH:0] d_eff;
    logic [WIDTH:0] d_lo;
    logic [WIDTH:0] d_hi;
    logic [WIDTH:0] r;
    logic [WIDTH:0] f;
    logic [WIDTH:0] f_wrap;

    always_comb begin
        c = {1'b0, cycle};
        p = {1'b0, phase};
`ifdef PWM_DUTY_CLAMP_EN
        d_eff = (duty > cycle) ? c : {1'b0, duty};
`else
        d_eff = {1'b0, duty};
`endif
        // odd duty puts the extra count on the fall side
        d_lo = d_eff >> 1;
        d_hi = d_eff - d_lo;
        r = (p >= d_lo) ? (p - d_lo) : (p + c - d_lo);
        f = p + d_hi;
        f_wrap = (f >= c) ? (f - c) : f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
            full <= 1'b0;
        end else if (en) begin
            rise <= r[WIDTH-1:0];
            fall <= f_wrap[WIDTH-1:0];
            full <= (d_eff == c);
        end
    end

endmodule

// File: rtl/pwm_preconditioner.sv
// Walks all transducers through one shared edge calculator into a shadow
// bank, then commits the bank in a single cycle. Clamp via PWM_DUTY_CLAMP_EN.
module pwm_preconditioner
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = PWM_DEPTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [WIDTH*DEPTH-1:0] CYCLE,
    input  logic [WIDTH*DEPTH-1:0] DUTY,
    input  logic [WIDTH*DEPTH-1:0] PHASE,
    output logic [WIDTH*DEPTH-1:0] RISE,
    output logic [WIDTH*DEPTH-1:0] FALL,
    output logic [DEPTH-1:0]       FULL,
    output logic                   BUSY,
    output logic                   DONE
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    pwm_pre_state_t state;

    logic [IW-1:0] idx;
    logic [IW-1:0] w_idx;
    logic          issue;
    logic          wv;
    logic          commit_q;

    logic [WIDTH*DEPTH-1:0] cyc_q;
    logic [WIDTH*DEPTH-1:0] duty_q;
    logic [WIDTH*DEPTH-1:0] ph_q;
    logic [WIDTH*DEPTH-1:0] sh_rise;
    logic [WIDTH*DEPTH-1:0] sh_fall;
    logic [DEPTH-1:0]       sh_full;

    logic [WIDTH-1:0] c_rise;
    logic [WIDTH-1:0] c_fall;
    logic             c_full;

    pwm_edge_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .clk   (CLK),
        .rst   (RST),
        .en    (issue),
        .cycle (cyc_q[idx*WIDTH +: WIDTH]),
        .duty  (duty_q[idx*WIDTH +: WIDTH]),
        .phase (ph_q[idx*WIDTH +: WIDTH]),
        .rise  (c_rise),
        .fall  (c_fall),
        .full  (c_full)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            w_idx    <= '0;
            issue    <= 1'b0;
            wv       <= 1'b0;
            commit_q <= 1'b0;
            cyc_q    <= '0;
            duty_q   <= '0;
            ph_q     <= '0;
            sh_rise  <= '0;
            sh_fall  <= '0;
            sh_full  <= '0;
            RISE     <= '0;
            FALL     <= '0;
            FULL     <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE     <= commit_q;
            commit_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        cyc_q  <= CYCLE;
                        duty_q <= DUTY;
                        ph_q   <= PHASE;
                        idx    <= '0;
                        issue  <= 1'b1;
                        wv     <= 1'b0;
                        BUSY   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // calc output lags the select by one clock
                    wv    <= issue;
                    w_idx <= idx;
                    if (issue) begin
                        if (idx == LAST) begin
                            issue <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    if (wv) begin
                        sh_rise[w_idx*WIDTH +: WIDTH] <= c_rise;
                        sh_fall[w_idx*WIDTH +: WIDTH] <= c_fall;
                        sh_full[w_idx]                <= c_full;
                        if (w_idx == LAST) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    RISE     <= sh_rise;
                    FALL     <= sh_fall;
                    FULL     <= sh_full;
                    idx      <= '0;
                    wv       <= 1'b0;
                    BUSY     <= 1'b0;
                    commit_q <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Randomized self-checking bench for pwm_preconditioner against a
// modular-arithmetic reference model.
module tb_pwm_preconditioner;

    localparam int W = 13;
    localparam int D = 249;

    logic           CLK;
    logic           RST;
    logic           START;
    logic [W*D-1:0] CYCLE;
    logic [W*D-1:0] DUTY;
    logic [W*D-1:0] PHASE;
    logic [W*D-1:0] RISE;
    logic [W*D-1:0] FALL;
    logic [D-1:0]   FULL;
    logic           BUSY;
    logic           DONE;

    int n_tests;
    int n_fail;

    int cy[D];
    int du[D];
    int ph[D];
    int exp_r[D];
    int exp_f[D];
    int exp_u[D];
    int old_r[D];
    int old_f[D];
    int old_u[D];

    pwm_preconditioner #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .CYCLE (CYCLE),
        .DUTY  (DUTY),
        .PHASE (PHASE),
        .RISE  (RISE),
        .FALL  (FALL),
        .FULL  (FULL),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edges wrap modulo the period around the pulse centre.
    function automatic void model(input int c, input int d, input int p,
                                  output int r, output int f, output int u);
        int de;
        int lo;
        int hi;
        de = d;
`ifdef PWM_DUTY_CLAMP_EN
        if (de > c) de = c;
`endif
        lo = de / 2;
        hi = de - lo;
        r = (p + c - lo) % c;
        f = (p + hi) % c;
        u = (de == c) ? 1 : 0;
    endfunction

    function automatic int rise_at(input int i);
        return int'(RISE[i*W +: W]);
    endfunction

    function automatic int fall_at(input int i);
        return int'(FALL[i*W +: W]);
    endfunction

    function automatic int mism(input bit use_old);
        int m;
        m = 0;
        for (int i = 0; i < D; i++) begin
            if (use_old) begin
                if (rise_at(i) != old_r[i] || fall_at(i) != old_f[i] ||
                    int'(FULL[i]) != old_u[i]) m++;
            end else begin
                if (rise_at(i) != exp_r[i] || fall_at(i) != exp_f[i] ||
                    int'(FULL[i]) != exp_u[i]) m++;
            end
        end
        return m;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < D; i++) begin
            cy[i] = $urandom_range(8191, 1);
            ph[i] = $urandom_range(cy[i] - 1, 0);
`ifdef PWM_DUTY_CLAMP_EN
            du[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(8191, 0)
                                                : $urandom_range(cy[i], 0);
`else
            du[i] = $urandom_range(cy[i], 0);
`endif
        end
    endtask

    task automatic fill_const(input int c, input int d, input int p);
        for (int i = 0; i < D; i++) begin
            cy[i] = c;
            du[i] = d;
            ph[i] = p;
        end
    endtask

    // Drives the arrays, pulses START and follows the pass to DONE.
    task automatic run_pass(input string tag, input int extra_at,
                            input bit scramble, input bit atom);
        int n;
        int done_n;
        int extra_done;
        for (int i = 0; i < D; i++) begin
            old_r[i] = exp_r[i];
            old_f[i] = exp_f[i];
            old_u[i] = exp_u[i];
            model(cy[i], du[i], ph[i], exp_r[i], exp_f[i], exp_u[i]);
            CYCLE[i*W +: W] = W'(cy[i]);
            DUTY[i*W +: W]  = W'(du[i]);
            PHASE[i*W +: W] = W'(ph[i]);
        end
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check({tag, "_busy_start"}, int'(BUSY), 1);
        n = 0;
        done_n = -1;
        while (n < D + 20 && done_n < 0) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
            n++;
            if (atom && n < D + 2) check({tag, "_hold_old"}, mism(1'b1), 0);
            if (atom && n == D + 2) check({tag, "_commit_all"}, mism(1'b0), 0);
            if (DONE) done_n = n;
            if (n == extra_at) begin
                START = 1'b1;
                if (scramble) DUTY = '0;
            end
        end
        START = 1'b0;
        check({tag, "_latency"}, done_n, D + 3);
        check({tag, "_busy_end"}, int'(BUSY), 0);
        extra_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) extra_done++;
        end
        check({tag, "_no_extra"}, extra_done, 0);
        check({tag, "_bank"}, mism(1'b0), 0);
    endtask

    initial begin
        int idle_busy;
        int extra;
        n_tests = 0;
        n_fail  = 0;
        START = 1'b0;
        CYCLE = '0;
        DUTY  = '0;
        PHASE = '0;
        for (int i = 0; i < D; i++) begin
            exp_r[i] = 0;
            exp_f[i] = 0;
            exp_u[i] = 0;
        end
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rise", int'(|RISE), 0);
        check("rst_fall", int'(|FALL), 0);
        check("rst_full", int'(|FULL), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        @(negedge CLK);
        RST = 1'b0;

        fill_const(4096, 2048, 0);
        run_pass("t1", -1, 1'b0, 1'b0);
        check("t1_rise0", rise_at(0), 3072);
        check("t1_fall0", fall_at(0), 1024);
        check("t1_full0", int'(FULL[0]), 0);

        fill_const(4096, 0, 100);
        run_pass("t2a", -1, 1'b0, 1'b0);
        check("t2a_rise", rise_at(7), 100);
        check("t2a_fall", fall_at(7), 100);
        check("t2a_full", int'(FULL[7]), 0);
        fill_const(4096, 3, 0);
        run_pass("t2b", -1, 1'b0, 1'b0);
        check("t2b_rise", rise_at(3), 4095);
        check("t2b_fall", fall_at(3), 2);

        fill_random();
        cy[D-1] = 4097;
        du[D-1] = 4097;
        ph[D-1] = 4096;
        run_pass("t3", -1, 1'b0, 1'b0);
        check("t3_rise", rise_at(D - 1), 2048);
        check("t3_fall", fall_at(D - 1), 2048);
        check("t3_full", int'(FULL[D-1]), 1);

`ifdef PWM_DUTY_CLAMP_EN
        fill_const(4096, 5000, 0);
        run_pass("t4", -1, 1'b0, 1'b0);
        check("t4_rise", rise_at(11), 2048);
        check("t4_fall", fall_at(11), 2048);
        check("t4_full", int'(FULL[11]), 1);
`endif

        for (int p = 0; p < 3; p++) begin
            fill_random();
            run_pass("rnd", -1, 1'b0, 1'b0);
        end

        fill_random();
        run_pass("atomA", -1, 1'b0, 1'b0);
        fill_random();
        run_pass("atomB", 50, 1'b1, 1'b1);
        fill_random();
        run_pass("commit_start", D + 1, 1'b0, 1'b1);

        fill_random();
        for (int i = 0; i < D; i++) begin
            CYCLE[i*W +: W] = W'(cy[i]);
            DUTY[i*W +: W]  = W'(du[i]);
            PHASE[i*W +: W] = W'(ph[i]);
        end
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (100) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("midrst_rise", int'(|RISE), 0);
        check("midrst_fall", int'(|FALL), 0);
        check("midrst_full", int'(|FULL), 0);
        check("midrst_busy", int'(BUSY), 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < D; i++) begin
            exp_r[i] = 0;
            exp_f[i] = 0;
            exp_u[i] = 0;
        end
        extra = 0;
        idle_busy = 0;
        for (int k = 0; k < D + 10; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) extra++;
            if (BUSY) idle_busy++;
        end
        check("midrst_no_done", extra, 0);
        check("midrst_idle", idle_busy, 0);
        run_pass("after_rst", -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
